ivl_uvm_phase_ctrl: RTL and testbench
=====================================

IVL_UVM_PHASE_CTRL -- requirements
Module: ivl_uvm_phase_ctrl

Interface
REQ-001 Parameter N_REQ, default 4: number of objection requesters, range 1-16.
REQ-002 Parameter CNT_W, default 8: objection counter width.
REQ-003 Parameter TMO_W, default 20: drain and timeout counter width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: single-cycle pulse that begins a phase run; honoured only in IDLE or DONE.
REQ-007 Port raise, input, N_REQ: per-requester raise-objection strobe, one bit per requester.
REQ-008 Port drop, input, N_REQ: per-requester drop-objection strobe, one bit per requester.
REQ-009 Port drain_cycles, input, TMO_W: quiet cycles required before a phase ends; 0 means end on the next cycle.
REQ-010 Port timeout_cycles, input, TMO_W: global run limit in cycles; 0 disables the limit.
REQ-011 Port phase, output, 3: current phase encoding: 0 IDLE, 1 RESET, 2 CONFIGURE, 3 MAIN, 4 SHUTDOWN, 5 DONE.
REQ-012 Port phase_start, output, 1: one-cycle pulse in the first cycle of each of phases 1-4.
REQ-013 Port phase_done, output, 1: one-cycle pulse in the last cycle of each of phases 1-4.
REQ-014 Port obj_count, output, CNT_W: current outstanding-objection count.
REQ-015 Port test_done, output, 1: high while in DONE.
REQ-016 Port err_underflow, output, 1: sticky flag for a drop received at count 0.
REQ-017 Port err_overflow, output, 1: sticky flag for saturation at the maximum count.
REQ-018 Port err_timeout, output, 1: sticky flag set when the global limit expires.

Function
REQ-019 FSM states: IDLE, RUN (covers phases 1-4, with sub-states WAIT and DRAIN), DONE.
REQ-020 start in IDLE or DONE -> next cycle: phase=1, phase_start=1, obj_count=0, all error flags cleared, global counter=0.
REQ-021 Objection update applies only in phases 1-4; raise and drop are ignored in IDLE and DONE.
REQ-022 Objection update rule: delta = popcount(raise & ~drop) - popcount(drop & ~raise); a requester with both bits set has no effect.
REQ-023 Underflow: if the result is below 0, obj_count=0 and err_underflow=1.
REQ-024 Overflow: if the result exceeds 2^CNT_W-1, obj_count saturates at that value and err_overflow=1.
REQ-025 WAIT: entered at phase start; on the first cycle in which the registered obj_count==0 with no net raise that cycle -> DRAIN, drain counter loaded with drain_cycles.
REQ-026 Minimum phase length: obj_count is not evaluated in the phase_start cycle, so every phase lasts at least 2 cycles.
REQ-027 DRAIN: the counter decrements each cycle; any raise bit set -> back to WAIT, count updated per REQ-022.
REQ-028 Drain completion: counter==0 with no raise -> phase_done=1 that cycle; the next cycle is phase+1 with phase_start=1.
REQ-029 Run completion: phase_done in SHUTDOWN (phase 4) -> DONE; test_done=1; obj_count holds its final value.
REQ-030 Global counter: increments every cycle in phases 1-4.
REQ-031 Timeout: timeout_cycles!=0 and counter==timeout_cycles-1 -> err_timeout=1, next state DONE, no phase_done pulse.
REQ-032 Timeout precedence: timeout takes precedence over a simultaneous phase_done.
REQ-033 start while in phases 1-4 is ignored.
REQ-034 start and a timeout in the same cycle: the timeout wins and start is dropped.
REQ-035 drain_cycles and timeout_cycles are sampled on use (load and compare); changing them mid-run affects only later loads and compares.

Reset
REQ-036 rst asserted -> immediately: phase=0, phase_start=0, phase_done=0, obj_count=0, test_done=0, all error flags 0, all counters 0.
REQ-037 rst asserted mid-run abandons the run with no phase_done pulse; the FSM resumes in IDLE after release.

Verification
REQ-038 No objections: drain_cycles=2, start, no raise -> phases 1-4 each last 4 cycles; DONE entered 16 cycles after the start cycle.
REQ-039 Objection hold: raise[0] in the MAIN start cycle, drop[0] 10 cycles later -> MAIN ends with phase_done exactly drain_cycles+1 cycles after the drop.
REQ-040 Re-raise during drain: raise[1] during DRAIN -> state returns to WAIT and no phase_done until the drain completes again.
REQ-041 Simultaneous strobes: raise=4'b0011, drop=4'b0010 at count 0 -> obj_count=1; then drop=4'b0011 -> obj_count=0 and err_underflow=1.
REQ-042 Timeout: timeout_cycles=50, raise held in CONFIGURE -> err_timeout=1 and phase=5 at run cycle 50, with no phase_done.
REQ-043 Mid-run reset: rst pulsed in MAIN with obj_count=3 -> all outputs 0; a later start runs a full clean sequence.

Source files
------------

// File: rtl/ivl_uvm_phase_ctrl.sv
// ivl_uvm_phase_ctrl
// Sequences a test run through the RESET, CONFIGURE, MAIN and SHUTDOWN
// phases.
// - A phase stays open while any requester holds an objection.
// - Once the objection count is zero, the phase waits through a quiet
//   drain window and then advances.
// - An optional global cycle limit aborts the run into DONE.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse; begins a run from IDLE or DONE
//   raise, drop         per-requester objection strobes (N_REQ bits)
//   drain_cycles        quiet cycles required before a phase ends
//   timeout_cycles      global run limit in cycles (0 = no limit)
//   phase               0 IDLE, 1 RESET, 2 CONFIGURE, 3 MAIN, 4 SHUTDOWN, 5 DONE
//   phase_start         high in the first cycle of phases 1-4
//   phase_done          high in the last cycle of phases 1-4
//   obj_count           outstanding objections
//   test_done           high while in DONE
//   err_underflow/err_overflow/err_timeout  sticky error flags
//   dbg_state           FSM state (0 IDLE, 1 WAIT, 2 DRAIN, 3 DONE)
module ivl_uvm_phase_ctrl #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_REQ-1:0] raise,
  input  logic [N_REQ-1:0] drop,
  input  logic [TMO_W-1:0] drain_cycles,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic [2:0]       phase,
  output logic             phase_start,
  output logic             phase_done,
  output logic [CNT_W-1:0] obj_count,
  output logic             test_done,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             err_timeout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] PH_RESET    = 3'd1;
  localparam logic [2:0] PH_SHUTDOWN = 3'd4;
  localparam logic [2:0] PH_DONE     = 3'd5;
  localparam int         EW          = CNT_W + 6;

  state_t           state_q;
  logic [2:0]       phase_q;
  logic             phase_start_q;
  logic [CNT_W-1:0] obj_q;
  logic             err_u_q, err_o_q, err_t_q;
  logic [TMO_W-1:0] drain_q;
  logic [TMO_W-1:0] gcnt_q;

  logic [4:0]       up_cnt, dn_cnt;
  logic [EW-1:0]    plus_w, res_w;
  logic             under, over;
  logic [CNT_W-1:0] obj_d;
  logic             in_run, net_raise, any_raise, quiet, tmo_hit, done_now;

  // A requester with both strobes set cancels itself out.
  always_comb begin
    up_cnt = '0;
    dn_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_cnt = up_cnt + 5'(raise[i] & ~drop[i]);
      dn_cnt = dn_cnt + 5'(drop[i] & ~raise[i]);
    end
  end

  // Count update in a widened domain so both clamps are visible.
  always_comb begin
    plus_w = EW'(obj_q) + EW'(up_cnt);
    under  = plus_w < EW'(dn_cnt);
    res_w  = plus_w - EW'(dn_cnt);
    over   = !under && (res_w > EW'({CNT_W{1'b1}}));
    if (under)     obj_d = '0;
    else if (over) obj_d = '1;
    else           obj_d = res_w[CNT_W-1:0];
  end

  assign in_run    = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign net_raise = up_cnt > dn_cnt;
  assign any_raise = |raise;
  // The count is not looked at in a phase's first cycle, so every phase
  // lasts at least two cycles.
  assign quiet     = (state_q == S_WAIT) && !phase_start_q && (obj_q == '0) && !net_raise;
  assign tmo_hit   = in_run && (timeout_cycles != '0) &&
                     (gcnt_q == timeout_cycles - TMO_W'(1));
  // With a zero drain window the quiet cycle itself is the last one.
  // A raise in the final drain cycle cancels the end, so this stays
  // combinational on the strobes.
  assign done_now  = !tmo_hit &&
                     ((quiet && (drain_cycles == '0)) ||
                      ((state_q == S_DRAIN) && !any_raise && (drain_q == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      phase_start_q <= 1'b0;
      obj_q         <= '0;
      err_u_q       <= 1'b0;
      err_o_q       <= 1'b0;
      err_t_q       <= 1'b0;
      drain_q       <= '0;
      gcnt_q        <= '0;
    end else begin
      phase_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_WAIT;
            phase_q       <= PH_RESET;
            phase_start_q <= 1'b1;
            obj_q         <= '0;
            err_u_q       <= 1'b0;
            err_o_q       <= 1'b0;
            err_t_q       <= 1'b0;
            drain_q       <= '0;
            gcnt_q        <= '0;
          end
        end
        default: begin
          obj_q  <= obj_d;
          gcnt_q <= gcnt_q + TMO_W'(1);
          if (under) err_u_q <= 1'b1;
          if (over)  err_o_q <= 1'b1;
          if (tmo_hit) begin
            err_t_q <= 1'b1;
            state_q <= S_DONE;
            phase_q <= PH_DONE;
          end else if (done_now) begin
            if (phase_q == PH_SHUTDOWN) begin
              state_q <= S_DONE;
              phase_q <= PH_DONE;
            end else begin
              state_q       <= S_WAIT;
              phase_q       <= phase_q + 3'd1;
              phase_start_q <= 1'b1;
            end
          end else if (state_q == S_WAIT) begin
            if (quiet) begin
              // Loaded one short: the quiet cycle counts toward the window.
              state_q <= S_DRAIN;
              drain_q <= drain_cycles - TMO_W'(1);
            end
          end else begin
            if (any_raise) state_q <= S_WAIT;
            else           drain_q <= drain_q - TMO_W'(1);
          end
        end
      endcase
    end
  end

  assign phase         = phase_q;
  assign phase_start   = phase_start_q;
  assign phase_done    = done_now;
  assign obj_count     = obj_q;
  assign test_done     = (state_q == S_DONE);
  assign err_underflow = err_u_q;
  assign err_overflow  = err_o_q;
  assign err_timeout   = err_t_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ivl_uvm_phase_ctrl.sv
// Bench for ivl_uvm_phase_ctrl: directed scenario tasks plus a randomized
// run compared against a cycle-level behavioural model.
module tb_ivl_uvm_phase_ctrl;
  localparam int N_REQ   = 4;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 20;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_REQ-1:0] raise, drop;
  logic [TMO_W-1:0] drain_cycles, timeout_cycles;
  logic [2:0]       phase;
  logic             phase_start, phase_done, test_done;
  logic [CNT_W-1:0] obj_count;
  logic             err_underflow, err_overflow, err_timeout;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  ivl_uvm_phase_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .raise(raise), .drop(drop),
    .drain_cycles(drain_cycles), .timeout_cycles(timeout_cycles),
    .phase(phase), .phase_start(phase_start), .phase_done(phase_done),
    .obj_count(obj_count), .test_done(test_done),
    .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // Tracks the phase number, how many consecutive quiet cycles have been
  // seen, and how many quiet cycles that phase needs (fixed when the
  // quiet run begins).
  int m_phase, m_streak, m_target, m_cnt, m_gc;
  bit m_first, m_eu, m_eo, m_et;

  task automatic model_clear();
    m_phase = 0; m_streak = 0; m_target = 0; m_cnt = 0; m_gc = 0;
    m_first = 0; m_eu = 0; m_eo = 0; m_et = 0;
  endtask

  task automatic model_step(input bit st, input logic [3:0] r, input logic [3:0] d,
                            input int dc, input int tc, output bit pd);
    int up, dn, n;
    bit tmo, calm, fin;
    pd = 0;
    if (m_phase == 0 || m_phase == 5) begin
      if (st) begin
        m_phase = 1; m_first = 1; m_streak = 0; m_cnt = 0; m_gc = 0;
        m_eu = 0; m_eo = 0; m_et = 0;
      end
    end else begin
      up  = $countones(r & ~d);
      dn  = $countones(d & ~r);
      tmo = (tc != 0) && (m_gc == tc - 1);
      if (m_streak == 0) calm = !m_first && (m_cnt == 0) && (up <= dn);
      else               calm = (r == 4'b0000);
      if (calm && m_streak == 0) m_target = dc + 1;
      fin = calm && (m_streak + 1 == m_target) && !tmo;
      pd  = fin;
      n = m_cnt + up - dn;
      if (n < 0)            begin m_cnt = 0;       m_eu = 1; end
      else if (n > CNT_MAX) begin m_cnt = CNT_MAX; m_eo = 1; end
      else                  m_cnt = n;
      m_gc++;
      if (tmo) begin
        m_et = 1; m_phase = 5; m_first = 0; m_streak = 0;
      end else if (fin) begin
        m_phase++;
        m_first  = (m_phase != 5);
        m_streak = 0;
      end else begin
        m_first  = 0;
        m_streak = calm ? m_streak + 1 : 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    start = 0; raise = '0; drop = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; set_idle();
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    next_cycle();
  endtask

  task automatic pulse_start();
    start = 1;
    next_cycle();
    start = 0;
  endtask

  task automatic wait_phase_start(input logic [2:0] ph, output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (phase == ph && phase_start) begin ok = 1; break; end
      next_cycle();
    end
  endtask

  // Checks a run with no objections from its first cycle through DONE.
  task automatic run_clean_sequence(input int d, input string tag);
    int len;
    logic [2:0] eph;
    bit eps, epd, etd;
    len = d + 2;
    set_idle();
    for (int k = 0; k <= 4 * len; k++) begin
      eph = (k < 4 * len) ? 3'(1 + k / len) : 3'd5;
      eps = (k < 4 * len) && (k % len == 0);
      epd = (k < 4 * len) && (k % len == len - 1);
      etd = (k == 4 * len);
      total++;
      if ({phase, phase_start, test_done} !== {eph, eps, etd}) begin
        bad++;
        $display("FAIL %s_seq k=%0d phase/start/done got %0d/%0b/%0b want %0d/%0b/%0b",
                 tag, k, phase, phase_start, test_done, eph, eps, etd);
      end
      #1;
      total++;
      if (phase_done !== epd) begin
        bad++;
        $display("FAIL %s_phase_done k=%0d got %0b want %0b", tag, k, phase_done, epd);
      end
      if (k < 4 * len) next_cycle();
    end
    total++;
    if ({obj_count, err_underflow, err_overflow, err_timeout} !== {8'd0, 3'b000}) begin
      bad++;
      $display("FAIL %s_end count/errs got %0d/%0b%0b%0b want 0/000", tag, obj_count,
               err_underflow, err_overflow, err_timeout);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    set_idle(); drain_cycles = 2; timeout_cycles = 0;
    rst = 1;
    #1;
    total++;
    if ({phase, phase_start, phase_done, obj_count, test_done, err_underflow,
         err_overflow, err_timeout, dbg_state} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs phase=%0d start=%0b done=%0b count=%0d tdone=%0b errs=%0b%0b%0b state=%0d want all 0",
               phase, phase_start, phase_done, obj_count, test_done, err_underflow,
               err_overflow, err_timeout, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    next_cycle();
    total++;
    if (phase !== 3'd0) begin
      bad++;
      $display("FAIL reset_idle phase got %0d want 0", phase);
    end
  endtask

  task automatic test_no_objection();
    do_reset();
    drain_cycles = 2; timeout_cycles = 0;
    pulse_start();
    run_clean_sequence(2, "no_obj");
  endtask

  task automatic test_obj_hold();
    bit ok, hold_ok;
    int first;
    do_reset();
    drain_cycles = 3; timeout_cycles = 0;
    pulse_start();
    wait_phase_start(3'd3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hold_reach_main got no MAIN start want MAIN start"); end
    raise = 4'b0001;
    next_cycle();
    raise = '0;
    hold_ok = 1;
    for (int k = 1; k <= 9; k++) begin
      hold_ok &= (obj_count === 8'd1);
      #1 hold_ok &= (phase_done === 1'b0);
      next_cycle();
    end
    drop = 4'b0001;
    #1 hold_ok &= (phase_done === 1'b0);
    next_cycle();
    drop = '0;
    total++;
    if (hold_ok !== 1'b1) begin bad++; $display("FAIL hold_window got early end want held count 1"); end
    first = -1;
    for (int j = 1; j <= 10; j++) begin
      #1;
      if (phase_done === 1'b1) begin first = j; break; end
      next_cycle();
    end
    total++;
    if (first != 4 || phase !== 3'd3) begin
      bad++;
      $display("FAIL hold_drain_len got %0d in phase %0d want 4 in phase 3", first, phase);
    end
  endtask

  task automatic test_redrain();
    int first;
    do_reset();
    drain_cycles = 4; timeout_cycles = 0;
    pulse_start();
    first = -1;
    for (int k = 0; k <= 12; k++) begin
      if (k == 4) begin
        total++;
        if (obj_count !== 8'd1) begin bad++; $display("FAIL redrain_count got %0d want 1", obj_count); end
      end
      raise = (k == 3) ? 4'b0010 : 4'b0000;
      drop  = (k == 4) ? 4'b0010 : 4'b0000;
      #1;
      if (phase_done === 1'b1 && first < 0) first = k;
      next_cycle();
    end
    set_idle();
    total++;
    if (first != 9) begin bad++; $display("FAIL redrain_first_done got %0d want 9", first); end
  endtask

  task automatic test_strobes();
    do_reset();
    drain_cycles = 5; timeout_cycles = 0;
    pulse_start();
    raise = 4'b0011; drop = 4'b0010;
    next_cycle();
    set_idle();
    total++;
    if ({obj_count, err_underflow} !== {8'd1, 1'b0}) begin
      bad++; $display("FAIL strobes_mixed got %0d/%0b want 1/0", obj_count, err_underflow);
    end
    drop = 4'b0011;
    next_cycle();
    set_idle();
    total++;
    if ({obj_count, err_underflow} !== {8'd0, 1'b1}) begin
      bad++; $display("FAIL strobes_underflow got %0d/%0b want 0/1", obj_count, err_underflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drain_cycles = 0; timeout_cycles = 0;
    pulse_start();
    raise = 4'hF;
    for (int k = 0; k < 64; k++) begin
      if (k == 63) begin
        total++;
        if ({obj_count, err_overflow} !== {8'd252, 1'b0}) begin
          bad++; $display("FAIL overflow_pre got %0d/%0b want 252/0", obj_count, err_overflow);
        end
      end
      next_cycle();
    end
    raise = '0;
    total++;
    if ({obj_count, err_overflow, err_underflow} !== {8'd255, 1'b1, 1'b0}) begin
      bad++; $display("FAIL overflow_sat got %0d/%0b/%0b want 255/1/0", obj_count, err_overflow, err_underflow);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] eph;
    do_reset();
    drain_cycles = 2; timeout_cycles = 50;
    pulse_start();
    for (int k = 0; k <= 51; k++) begin
      eph = (k < 4) ? 3'd1 : (k < 50) ? 3'd2 : 3'd5;
      total++;
      if ({phase, err_timeout} !== {eph, (k >= 50)}) begin
        bad++;
        $display("FAIL timeout_seq k=%0d phase/err got %0d/%0b want %0d/%0b", k, phase, err_timeout, eph, (k >= 50));
      end
      raise = (k >= 4) ? 4'b0001 : 4'b0000;
      start = (k == 49);
      #1;
      total++;
      if (phase_done !== (k == 3)) begin
        bad++; $display("FAIL timeout_phase_done k=%0d got %0b want %0b", k, phase_done, (k == 3));
      end
      next_cycle();
    end
    set_idle();
    total++;
    if ({obj_count, test_done, phase} !== {8'd46, 1'b1, 3'd5}) begin
      bad++; $display("FAIL timeout_final count/tdone/phase got %0d/%0b/%0d want 46/1/5", obj_count, test_done, phase);
    end
  endtask

  // Restart straight out of DONE left by the timeout scenario.
  task automatic test_back_to_back();
    drain_cycles = 0; timeout_cycles = 0;
    pulse_start();
    total++;
    if ({phase, obj_count, err_timeout} !== {3'd1, 8'd0, 1'b0}) begin
      bad++; $display("FAIL b2b_restart phase/count/err got %0d/%0d/%0b want 1/0/0", phase, obj_count, err_timeout);
    end
    run_clean_sequence(0, "b2b");
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    drain_cycles = 1; timeout_cycles = 0;
    pulse_start();
    wait_phase_start(3'd3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_reach_main got no MAIN start want MAIN start"); end
    raise = 4'b0111;
    next_cycle();
    raise = '0;
    total++;
    if (obj_count !== 8'd3) begin bad++; $display("FAIL midrst_count got %0d want 3", obj_count); end
    #2 rst = 1;
    #1;
    total++;
    if ({phase, phase_start, phase_done, obj_count, test_done, err_underflow,
         err_overflow, err_timeout} !== 17'd0) begin
      bad++;
      $display("FAIL midrst_outputs phase=%0d count=%0d done=%0b want all 0", phase, obj_count, phase_done);
    end
    @(negedge clk);
    rst = 0;
    model_clear();
    next_cycle();
    pulse_start();
    run_clean_sequence(1, "midrst");
  endtask

  function automatic logic [3:0] rand_mask(input int p);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = ($urandom_range(0, p - 1) == 0);
    return m;
  endfunction

  task automatic test_random();
    bit pd, busy;
    int dc, tc;
    do_reset();
    dc = 1; tc = 0;
    drain_cycles = TMO_W'(dc); timeout_cycles = TMO_W'(tc);
    for (int c = 0; c < 3000; c++) begin
      total++;
      if ({phase, phase_start, obj_count, test_done, err_underflow, err_overflow, err_timeout} !==
          {3'(m_phase), m_first, 8'(m_cnt), (m_phase == 5), m_eu, m_eo, m_et}) begin
        bad++;
        $display("FAIL random_state c=%0d got ph=%0d ps=%0b cnt=%0d td=%0b e=%0b%0b%0b want ph=%0d ps=%0b cnt=%0d e=%0b%0b%0b",
                 c, phase, phase_start, obj_count, test_done, err_underflow, err_overflow, err_timeout,
                 m_phase, m_first, m_cnt, m_eu, m_eo, m_et);
      end
      if (c % 97 == 0) begin
        dc = $urandom_range(0, 3);
        tc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(20, 120);
        drain_cycles = TMO_W'(dc); timeout_cycles = TMO_W'(tc);
      end
      busy  = ((c / 50) % 2 == 0);
      start = ($urandom_range(0, 19) == 0);
      raise = busy ? rand_mask(4) : rand_mask(32);
      drop  = busy ? rand_mask(4) : rand_mask(6);
      #1;
      model_step(start, raise, drop, dc, tc, pd);
      total++;
      if (phase_done !== pd) begin
        bad++; $display("FAIL random_phase_done c=%0d got %0b want %0b", c, phase_done, pd);
      end
      next_cycle();
    end
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 0;
    set_idle();
    drain_cycles = 0; timeout_cycles = 0;
    model_clear();
    test_reset();
    test_no_objection();
    test_obj_hold();
    test_redrain();
    test_strobes();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
